btb_way_pn: RTL and testbench

Parametrised direct-mapped branch-target-buffer way for the fetch stage. It replaces the fixed 32-entry, 16-bit way. The new block has configurable depth, PC/target width and index offset, real tag compare, and N-bit saturating direction counters. It also adds registered lookup outputs and a multi-cycle flush sequencer. The fetch unit instantiates one or more ways under a BTB top that performs way selection and replacement.

---
 rtl/btb_way_pn_if.sv | 37 +++
 rtl/btb_way_pn.sv | 153 +++++++++++++++
 tb/tb_btb_way_pn.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/btb_way_pn_if.sv
// Lookup, update and flush signal bundle for one BTB way.
// master = fetch-side BTB top, slave = the way itself.
interface btb_way_pn_if #(
    parameter int PC_W  = 16,
    parameter int TGT_W = 16
);
    logic             lk_req;
    logic [PC_W-1:0]  lk_pc;
    logic             lk_valid;
    logic             lk_hit;
    logic             lk_taken;
    logic [TGT_W-1:0] lk_target;
    logic             upd_en;
    logic             upd_alloc;
    logic             upd_taken;
    logic [PC_W-1:0]  upd_pc;
    logic [TGT_W-1:0] upd_target;
    logic             alloc_empty;
    logic             flush_req;
    logic             flush_busy;

    modport master (
        output lk_req, lk_pc,
        output upd_en, upd_alloc, upd_taken, upd_pc, upd_target,
        output flush_req,
        input  lk_valid, lk_hit, lk_taken, lk_target,
        input  alloc_empty, flush_busy
    );

    modport slave (
        input  lk_req, lk_pc,
        input  upd_en, upd_alloc, upd_taken, upd_pc, upd_target,
        input  flush_req,
        output lk_valid, lk_hit, lk_taken, lk_target,
        output alloc_empty, flush_busy
    );
endinterface

// File: rtl/btb_way_pn.sv
// Direct-mapped BTB way: tag compare, saturating direction
// counters, registered lookup and a walking flush sequencer.
module btb_way_pn #(
    parameter int PC_W  = 16,
    parameter int TGT_W = 16,
    parameter int IDX_W = 5,
    parameter int OFS_W = 0,
    parameter int CTR_W = 2
) (
    input logic         clk,
    input logic         rst,
    btb_way_pn_if.slave bus
);
    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_W = PC_W - OFS_W - IDX_W;
    localparam int TAG_L = OFS_W + IDX_W;
    localparam logic [CTR_W-1:0] CTR_WT = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WN = CTR_WT - CTR_W'(1);

    typedef enum logic {
        IDLE,
        FLUSH
    } st_t;

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [TGT_W-1:0] tgt_mem [DEPTH];
    logic [CTR_W-1:0] ctr_mem [DEPTH];

    st_t              state;
    st_t              state_nxt;
    logic [IDX_W-1:0] walk;
    logic             busy;
    logic             clr_en;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit_c;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_match;
    logic             up_ok;
    logic [CTR_W-1:0] up_ctr;

    logic             lk_valid_q;
    logic             lk_hit_q;
    logic             lk_taken_q;
    logic [TGT_W-1:0] lk_target_q;

    assign lk_idx = bus.lk_pc[TAG_L-1:OFS_W];
    assign lk_tag = bus.lk_pc[PC_W-1:TAG_L];
    assign up_idx = bus.upd_pc[TAG_L-1:OFS_W];
    assign up_tag = bus.upd_pc[PC_W-1:TAG_L];
    assign up_ctr = ctr_mem[up_idx];

    // Lookup hit and update qualification; both are masked while flushing.
    always_comb begin
        lk_hit_c = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag) && !busy;
        up_match = valid[up_idx] && (tag_mem[up_idx] == up_tag);
        up_ok    = bus.upd_en && !busy;
    end

    assign bus.alloc_empty = !valid[up_idx] || busy;
    assign bus.flush_busy  = busy;
    assign bus.lk_valid    = lk_valid_q;
    assign bus.lk_hit      = lk_hit_q;
    assign bus.lk_taken    = lk_taken_q;
    assign bus.lk_target   = lk_target_q;

    // Flush FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Flush FSM next state; requests during a flush are dropped.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.flush_req) state_nxt = FLUSH;
            FLUSH:   if (walk == '1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Flush FSM outputs.
    always_comb begin
        busy   = (state == FLUSH);
        clr_en = (state == FLUSH);
    end

    // Walk counter: loaded with 0 on flush start, stepped while flushing.
    always_ff @(posedge clk) begin
        if (!rst) begin
            walk <= '0;
        end else if (state == IDLE && bus.flush_req) begin
            walk <= '0;
        end else if (clr_en) begin
            walk <= walk + IDX_W'(1);
        end
    end

    // Valid bits: flush clears, allocate sets.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= '0;
        end else if (clr_en) begin
            valid[walk] <= 1'b0;
        end else if (up_ok && bus.upd_alloc) begin
            valid[up_idx] <= 1'b1;
        end
    end

    // Entry payload: allocate overwrites, train needs a tag hit.
    always_ff @(posedge clk) begin
        if (rst && up_ok) begin
            if (bus.upd_alloc) begin
                tag_mem[up_idx] <= up_tag;
                tgt_mem[up_idx] <= bus.upd_target;
                ctr_mem[up_idx] <= bus.upd_taken ? CTR_WT : CTR_WN;
            end else if (up_match) begin
                if (bus.upd_taken) begin
                    tgt_mem[up_idx] <= bus.upd_target;
                    if (up_ctr != '1) begin
                        ctr_mem[up_idx] <= up_ctr + CTR_W'(1);
                    end
                end else if (up_ctr != '0) begin
                    ctr_mem[up_idx] <= up_ctr - CTR_W'(1);
                end
            end
        end
    end

    // Registered lookup result; holds when no request is issued.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lk_valid_q  <= 1'b0;
            lk_hit_q    <= 1'b0;
            lk_taken_q  <= 1'b0;
            lk_target_q <= '0;
        end else if (bus.lk_req) begin
            lk_valid_q  <= 1'b1;
            lk_hit_q    <= lk_hit_c;
            lk_taken_q  <= lk_hit_c && ctr_mem[lk_idx][CTR_W-1];
            lk_target_q <= lk_hit_c ? tgt_mem[lk_idx] : '0;
        end else begin
            lk_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_btb_way_pn.sv
// Directed-vector bench for btb_way_pn with default parameters.
// Inputs change 1ns after the rising edge; outputs are sampled there.
module tb_btb_way_pn;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   n;

    btb_way_pn_if #(.PC_W(16), .TGT_W(16)) bus ();

    btb_way_pn dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [15:0] pc);
        bus.lk_req = 1'b1;
        bus.lk_pc  = pc;
        step();
        bus.lk_req = 1'b0;
    endtask

    task automatic upd(input logic [15:0] pc, input logic alloc,
                       input logic tk, input logic [15:0] tgt);
        bus.upd_en     = 1'b1;
        bus.upd_alloc  = alloc;
        bus.upd_taken  = tk;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
        step();
        bus.upd_en = 1'b0;
    endtask

    task automatic look_chk(input string tag, input logic [15:0] pc,
                            input logic hit, input logic tk,
                            input logic [15:0] tgt);
        lookup(pc);
        check({tag, "_v"}, 32'(bus.lk_valid), 32'd1);
        check({tag, "_hit"}, 32'(bus.lk_hit), 32'(hit));
        check({tag, "_tk"}, 32'(bus.lk_taken), 32'(tk));
        check({tag, "_tgt"}, 32'(bus.lk_target), 32'(tgt));
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        bus.lk_req = 1'b0;
        bus.lk_pc = '0;
        bus.upd_en = 1'b0;
        bus.upd_alloc = 1'b0;
        bus.upd_taken = 1'b0;
        bus.upd_pc = '0;
        bus.upd_target = '0;
        bus.flush_req = 1'b0;
        step();
        step();
        check("rst_v", 32'(bus.lk_valid), 32'd0);
        check("rst_hit", 32'(bus.lk_hit), 32'd0);
        check("rst_tgt", 32'(bus.lk_target), 32'd0);
        check("rst_busy", 32'(bus.flush_busy), 32'd0);
        rst = 1'b1;

        look_chk("cold", 16'h0023, 1'b0, 1'b0, 16'h0000);
        bus.upd_pc = 16'h0023;
        #1;
        check("empty0", 32'(bus.alloc_empty), 32'd1);

        upd(16'h0023, 1'b1, 1'b1, 16'h0100);
        check("empty1", 32'(bus.alloc_empty), 32'd0);
        look_chk("alloc", 16'h0023, 1'b1, 1'b1, 16'h0100);
        step();
        check("idle_v", 32'(bus.lk_valid), 32'd0);
        check("hold_hit", 32'(bus.lk_hit), 32'd1);
        check("hold_tgt", 32'(bus.lk_target), 32'h0100);
        look_chk("alias", 16'h0043, 1'b0, 1'b0, 16'h0000);

        upd(16'h0023, 1'b0, 1'b1, 16'h0100);
        upd(16'h0023, 1'b0, 1'b1, 16'h0120);
        look_chk("tr_t2", 16'h0023, 1'b1, 1'b1, 16'h0120);
        upd(16'h0023, 1'b0, 1'b0, 16'h0777);
        look_chk("tr_n1", 16'h0023, 1'b1, 1'b1, 16'h0120);
        upd(16'h0023, 1'b0, 1'b0, 16'h0777);
        look_chk("tr_n2", 16'h0023, 1'b1, 1'b0, 16'h0120);
        for (int i = 0; i < 3; i++) upd(16'h0023, 1'b0, 1'b0, 16'h0);
        look_chk("tr_n5", 16'h0023, 1'b1, 1'b0, 16'h0120);
        upd(16'h0023, 1'b0, 1'b1, 16'h0130);
        look_chk("tr_sat0", 16'h0023, 1'b1, 1'b0, 16'h0130);
        upd(16'h0023, 1'b0, 1'b1, 16'h0130);
        look_chk("tr_up2", 16'h0023, 1'b1, 1'b1, 16'h0130);
        upd(16'h0043, 1'b0, 1'b0, 16'h0999);
        upd(16'h0043, 1'b0, 1'b1, 16'h0999);
        look_chk("tr_miss", 16'h0023, 1'b1, 1'b1, 16'h0130);

        upd(16'h0000, 1'b1, 1'b1, 16'h0A00);
        upd(16'h0005, 1'b1, 1'b0, 16'h0A05);
        upd(16'h001F, 1'b1, 1'b1, 16'h0A1F);
        look_chk("pre_f31", 16'h001F, 1'b1, 1'b1, 16'h0A1F);
        look_chk("pre_f5", 16'h0005, 1'b1, 1'b0, 16'h0A05);

        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        n = 0;
        while (bus.flush_busy && n < 100) begin
            if (n == 2) begin
                bus.upd_pc = 16'h0023;
                #1;
                check("f_empty", 32'(bus.alloc_empty), 32'd1);
            end
            if (n == 3) begin
                bus.lk_req = 1'b1;
                bus.lk_pc  = 16'h001F;
            end
            if (n == 10) begin
                bus.upd_en     = 1'b1;
                bus.upd_alloc  = 1'b1;
                bus.upd_taken  = 1'b1;
                bus.upd_pc     = 16'h0027;
                bus.upd_target = 16'h0055;
            end
            if (n == 15) bus.flush_req = 1'b1;
            step();
            bus.lk_req = 1'b0;
            bus.upd_en = 1'b0;
            bus.flush_req = 1'b0;
            n++;
            if (n == 4) begin
                check("f_lk_v", 32'(bus.lk_valid), 32'd1);
                check("f_lk_hit", 32'(bus.lk_hit), 32'd0);
            end
        end
        check("f_len", 32'(n), 32'd32);
        look_chk("post0", 16'h0000, 1'b0, 1'b0, 16'h0000);
        look_chk("post5", 16'h0005, 1'b0, 1'b0, 16'h0000);
        look_chk("post31", 16'h001F, 1'b0, 1'b0, 16'h0000);
        look_chk("post7", 16'h0027, 1'b0, 1'b0, 16'h0000);
        look_chk("post3", 16'h0023, 1'b0, 1'b0, 16'h0000);

        bus.lk_req = 1'b1;
        bus.lk_pc  = 16'h0023;
        upd(16'h0023, 1'b1, 1'b1, 16'h0200);
        bus.lk_req = 1'b0;
        check("rbw_hit", 32'(bus.lk_hit), 32'd0);
        look_chk("rbw_next", 16'h0023, 1'b1, 1'b1, 16'h0200);

        upd(16'h001F, 1'b1, 1'b1, 16'h0B1F);
        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("mid_busy", 32'(bus.flush_busy), 32'd1);
        check("mid_hold", 32'(bus.lk_target), 32'h0200);
        rst = 1'b0;
        bus.lk_req = 1'b1;
        bus.lk_pc  = 16'h001F;
        step();
        bus.lk_req = 1'b0;
        rst = 1'b1;
        check("r2_busy", 32'(bus.flush_busy), 32'd0);
        check("r2_v", 32'(bus.lk_valid), 32'd0);
        check("r2_hit", 32'(bus.lk_hit), 32'd0);
        check("r2_tk", 32'(bus.lk_taken), 32'd0);
        check("r2_tgt", 32'(bus.lk_target), 32'd0);
        look_chk("r2_31", 16'h001F, 1'b0, 1'b0, 16'h0000);
        look_chk("r2_3", 16'h0023, 1'b0, 1'b0, 16'h0000);

        bus.flush_req = 1'b1;
        step();
        bus.flush_req = 1'b0;
        n = 0;
        while (bus.flush_busy && n < 100) begin
            step();
            n++;
        end
        check("f2_len", 32'(n), 32'd32);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
